// File: rtl/imem_loader.sv
// imem_loader: writes a length-prefixed little-endian byte image into imem port B and holds the CPU in reset until it is loaded.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte after the data.
module imem_loader #(
  parameter int ADDR_W    = 14,
  parameter int MAX_WORDS = 16384
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic [3:0]        imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_din,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);
`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, CHK, DONE, ERR} state_t;
  logic [7:0] csum_q;
`else
  typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, DONE, ERR} state_t;
`endif
  state_t state_q, state_d;
  logic rx_ready_q, busy_q, done_q, error_q, cpu_hold_q;
  logic [3:0] we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0] din_q;
  logic [ADDR_W:0] wl_q;
  logic [15:0] n_q, n_full;
  logic [1:0] idx_q;
  logic [23:0] part_q;
  logic xfer, take, last, idle, active_d;
  assign xfer = rx_valid && rx_ready_q;
  assign n_full = {rx_data, n_q[7:0]};
  assign idle = state_q inside {IDLE, DONE, ERR};
  // The cycle carrying the final write is still DATA, but accepts no byte.
  assign take = xfer && state_q == DATA && 32'(wl_q) != 32'(n_q);
  assign last = take && idx_q == 2'd3 && 32'(wl_q) + 32'd1 == 32'(n_q);
  assign active_d = !(state_d inside {IDLE, DONE, ERR});
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE, ERR: state_d = start ? LEN0 : state_q;
      LEN0: state_d = xfer ? LEN1 : LEN0;
      LEN1: state_d = !xfer ? LEN1 : (n_full == 16'd0 || 32'(n_full) > MAX_WORDS) ? ERR : DATA;
`ifdef IMEM_LOADER_CHECKSUM_EN
      DATA: state_d = last ? CHK : DATA;
      CHK: state_d = !xfer ? CHK : (rx_data == csum_q) ? DONE : ERR;
`else
      DATA: state_d = (32'(wl_q) == 32'(n_q)) ? DONE : DATA;
`endif
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      rx_ready_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      error_q <= 1'b0;
      cpu_hold_q <= 1'b1;
      we_q <= 4'h0;
      addr_q <= '0;
      din_q <= '0;
      wl_q <= '0;
      n_q <= '0;
      idx_q <= '0;
      part_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      rx_ready_q <= active_d;
      busy_q <= active_d;
      done_q <= state_d == DONE;
      error_q <= state_d == ERR;
      cpu_hold_q <= state_d != DONE;
      we_q <= 4'h0;
      if (idle && start) begin
        wl_q <= '0;
        idx_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_q <= '0;
`endif
      end
      if (xfer && state_q == LEN0) n_q[7:0] <= rx_data;
      if (xfer && state_q == LEN1) n_q[15:8] <= rx_data;
      if (take) begin
        idx_q <= idx_q + 2'd1;
        part_q <= {rx_data, part_q[23:8]};
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_q <= csum_q ^ rx_data;
`endif
        if (idx_q == 2'd3) begin
          we_q <= 4'hF;
          addr_q <= wl_q[ADDR_W-1:0];
          din_q <= {rx_data, part_q};
          wl_q <= wl_q + (ADDR_W+1)'(1);
        end
      end
    end
  end
  assign rx_ready = rx_ready_q;
  assign imem_we = we_q;
  assign imem_addr = addr_q;
  assign imem_din = din_q;
  assign cpu_hold = cpu_hold_q;
  assign busy = busy_q;
  assign done = done_q;
  assign error = error_q;
  assign words_loaded = wl_q;
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: table of image streams for imem_loader; expected writes are queued while bytes are driven and matched on each imem_we pulse.
module tb_imem_loader;
  logic clk = 0, reset = 0, start = 0, rx_valid = 0, rx_ready;
  logic [7:0] rx_data = 0;
  logic [3:0] imem_we;
  logic [13:0] imem_addr;
  logic [31:0] imem_din;
  logic cpu_hold, busy, done, error;
  logic [14:0] words_loaded;
  int checks = 0, fails = 0;

  imem_loader dut (
    .clk(clk), .reset(reset), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_din(imem_din),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] b [16];
    int len;
    bit gap;
    bit exp_done;
    bit exp_err;
    int exp_wl;
  } vec_t;

  typedef struct {
    logic [13:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q [$];
  wr_t e_m;
  logic [3:0] prev_we = 0;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam int NV = 6;
`else
  localparam int NV = 5;
`endif
  vec_t tv [NV];

  task automatic chk(input string nm, input logic [127:0] a, input logic [127:0] e);
    checks++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", nm, a, e);
    end
  endtask

  function automatic vec_t mk(input logic [127:0] s, input int len, input bit gap, input bit d, input bit e, input int wl);
    vec_t v;
    for (int i = 0; i < 16; i++) begin
      v.b[i] = 8'h00;
      if (i < len) v.b[i] = s[8*(len-1-i) +: 8];
    end
    v.len = len;
    v.gap = gap;
    v.exp_done = d;
    v.exp_err = e;
    v.exp_wl = wl;
    return v;
  endfunction

  always @(negedge clk) begin
    if (imem_we != 4'h0) begin
      checks++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL write_unexpected we=%h addr=%h din=%h", imem_we, imem_addr, imem_din);
      end else begin
        e_m = exp_q.pop_front();
        if ({imem_we, imem_addr, imem_din} !== {4'hF, e_m.addr, e_m.data} || prev_we != 4'h0) begin
          fails++;
          $display("FAIL write got we=%h addr=%h din=%h prev_we=%h exp we=f addr=%h din=%h prev_we=0",
                   imem_we, imem_addr, imem_din, prev_we, e_m.addr, e_m.data);
        end
      end
    end
    prev_we = imem_we;
  end

  task automatic do_start();
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic send(input vec_t v, input string nm);
    int i, cyc, n;
    bit odd;
    i = 0;
    cyc = 0;
    odd = 0;
    n = int'({v.b[1], v.b[0]});
    while (i < v.len && cyc < 200) begin
      @(negedge clk);
      cyc++;
      rx_valid = !(v.gap && odd);
      odd = !odd;
      rx_data = v.b[i];
      if (rx_valid && rx_ready) begin
        if (i >= 5 && (i - 2) % 4 == 3 && (i - 2) / 4 < n && n <= 16384)
          exp_q.push_back('{addr: 14'((i - 2) / 4), data: {v.b[i], v.b[i-1], v.b[i-2], v.b[i-3]}});
        i++;
      end
    end
    @(negedge clk);
    rx_valid = 0;
    chk({nm, "_bytes_taken"}, 128'(i), 128'(v.len));
  endtask

  task automatic finish_check(input vec_t v, input string nm);
    int cyc;
    cyc = 0;
    while (!(done || error) && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    repeat (2) @(negedge clk);
    chk({nm, "_done"}, 128'(done), 128'(v.exp_done));
    chk({nm, "_error"}, 128'(error), 128'(v.exp_err));
    chk({nm, "_cpu_hold"}, 128'(cpu_hold), 128'(!v.exp_done));
    chk({nm, "_words_loaded"}, 128'(words_loaded), 128'(v.exp_wl));
    chk({nm, "_idle_ready_busy"}, 128'({rx_ready, busy}), 128'(0));
    chk({nm, "_writes_pending"}, 128'(exp_q.size()), 128'(0));
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    do_start();
    send(v, nm);
    finish_check(v, nm);
  endtask

  localparam logic [69:0] RST_VALS = {1'b0, 4'h0, 14'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 15'h0};

  initial begin
    vec_t v;
`ifdef IMEM_LOADER_CHECKSUM_EN
    tv[0] = mk(128'h02001300500093001000C0, 11, 0, 1, 0, 2);
    tv[1] = mk(128'h02001300500093001000C0, 11, 1, 1, 0, 2);
    tv[4] = mk(128'h01007856341208, 7, 0, 1, 0, 1);
    tv[5] = mk(128'h02001300500093001000C1, 11, 0, 0, 1, 2);
`else
    tv[0] = mk(128'h02001300500093001000, 10, 0, 1, 0, 2);
    tv[1] = mk(128'h02001300500093001000, 10, 1, 1, 0, 2);
    tv[4] = mk(128'h010078563412, 6, 0, 1, 0, 1);
`endif
    tv[2] = mk(128'h0000, 2, 0, 0, 1, 0);
    tv[3] = mk(128'h0140, 2, 0, 0, 1, 0);
    repeat (3) @(negedge clk);
    chk("reset_values", 128'({rx_ready, imem_we, imem_addr, imem_din, cpu_hold, busy, done, error, words_loaded}), 128'(RST_VALS));
    reset = 1;
    @(negedge clk);
    chk("idle_no_ready", 128'({rx_ready, busy, cpu_hold}), 128'(3'b001));
    for (int k = 0; k < NV; k++) run_vec(tv[k], $sformatf("vec%0d", k));
    do_start();
    v = tv[0];
    v.len = 7;
    send(v, "midreset");
    reset = 0;
    @(negedge clk);
    chk("midreset_values", 128'({rx_ready, imem_we, imem_addr, imem_din, cpu_hold, busy, done, error, words_loaded}), 128'(RST_VALS));
    chk("midreset_writes_pending", 128'(exp_q.size()), 128'(0));
    reset = 1;
    run_vec(tv[0], "after_reset");
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
